aes_gcm_instance_scheduler: RTL and testbench
=============================================

Name: aes_gcm_instance_scheduler

Overview:
Sequences one AES-GCM instance at a time into the GCM pipeline, ahead of the stage that derives H and J0. Accepts a job descriptor (IV, AAD/PT block counts, bit lengths), then streams AAD blocks followed by PT blocks. Drives o_new_instance, o_pt_instance and o_instance_size consistently on every beat. Registered output stage with a downstream ready.

Parameters:
CNT_W, 32, width of AAD and PT block counters.
TIMEOUT_CYCLES, 1024, idle-input watchdog limit; used only with the optional feature.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_job_valid  in  1  descriptor valid
o_job_ready  out  1  descriptor accepted when valid & ready
i_job_iv  in  96  IV for the instance
i_job_aad_blks  in  CNT_W  number of 128-bit AAD blocks
i_job_pt_blks  in  CNT_W  number of 128-bit PT blocks
i_job_size  in  128  GCM length block {len(A) 64b, len(C) 64b}
i_blk_valid  in  1  input data block valid
o_blk_ready  out  1  input data block accepted when valid & ready
i_blk_data  in  128  AAD or PT block, in order
i_pipe_ready  in  1  downstream accepts the current output beat
o_valid  out  1  output beat valid
o_iv  out  96  instance IV
o_aad  out  128  AAD block, zero on PT beats
o_plain_text  out  128  PT block, zero on AAD beats
o_instance_size  out  128  latched i_job_size
o_new_instance  out  1  first beat of an instance
o_pt_instance  out  1  1 = PT beat, 0 = AAD beat
o_last  out  1  final beat of the instance
o_busy  out  1  FSM not in IDLE
o_abort  out  1  one-cycle pulse on watchdog abort; tied 0 without the optional feature

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0 except o_job_ready=1; counters and latched descriptor cleared. Reset mid-instance discards all in-flight state; o_valid drops immediately.
- Output register advances when (!o_valid | i_pipe_ready). o_blk_ready = FSM in AAD/PT & (!o_valid | i_pipe_ready). Latency is 1 cycle from block accept to o_valid.
- o_valid is held with stable data while i_pipe_ready=0.
- IDLE: o_job_ready=1. On accept, latch IV, counts and size; aad_rem=i_job_aad_blks, pt_rem=i_job_pt_blks; first_pending=1.
  - aad_rem>0 -> AAD.
  - aad_rem=0 & pt_rem>0 -> PT.
  - Both 0 -> EMPTY.
- AAD: each accepted block emits o_aad=data, o_pt_instance=0 and decrements aad_rem. At aad_rem 1->0: go to PT if pt_rem>0, else DONE with o_last=1.
- PT: same, with o_plain_text=data, o_pt_instance=1. At pt_rem 1->0: DONE with o_last=1.
- EMPTY: when the output register can advance, emit one beat with all data zero, o_pt_instance=0, o_new_instance=1, o_last=1; then DONE.
- o_new_instance=1 on the first emitted beat only (first_pending cleared on emit). A single-block instance has new_instance=last=1.
- DONE: wait until the last beat is handed off (o_valid=0 or i_pipe_ready=1), then go to IDLE. o_job_ready is 0 everywhere except IDLE, so no back-to-back overlap between instances.
- o_iv and o_instance_size are stable for the whole instance. o_busy=(state!=IDLE).
- Counters are CNT_W-bit and never wrap: decrement only when nonzero.

Optional Feature:
Macro AES_SCHED_TIMEOUT_EN.
- With it: a watchdog counts cycles in AAD/PT with i_blk_valid=0 and resets on any block accept. On reaching TIMEOUT_CYCLES: pulse o_abort, clear o_valid, go to IDLE, discard remaining counts.
- Without it: no counter; o_abort tied 0; the scheduler waits indefinitely.

Decomposition:
- Package aes_gcm_sched_pkg: FSM state enum (IDLE, AAD, PT, EMPTY, DONE), BLK_W=128, IV_W=96, SIZE_W=128.
- One natural sub-module, aes_gcm_sched_outreg: the valid/ready output holding register.
- The FSM and counters stay in the top module.

Test Plan:
- Job aad=2, pt=3, pipe_ready=1, blocks every cycle -> 5 beats: pt_instance 0,0,1,1,1; new_instance on beat 1; last on beat 5; o_job_ready returns 1 one cycle after the last handoff.
- Job aad=0, pt=1 -> single PT beat with new_instance=1, last=1, o_aad=0.
- Job aad=0, pt=0 -> single zero beat with new_instance=1, last=1, pt_instance=0.
- aad=1, pt=2 with i_pipe_ready low for 3 cycles on beat 2 -> beat 2 held stable, o_blk_ready=0 during the stall, no block lost or duplicated.
- rst_n asserted after beat 1 of a 4-block job -> o_valid=0 and o_busy=0 immediately; a new job after reset starts with new_instance=1.
- With AES_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8: job aad=2, feed 1 block, then idle -> o_abort pulses after 8 idle cycles, FSM returns to IDLE, o_job_ready=1.

Source files
------------

// File: rtl/aes_gcm_sched_pkg.sv
// ============================================================================
// Module   : aes_gcm_sched_pkg
// Purpose  : Shared types and widths for the AES-GCM instance scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_gcm_sched_pkg;

    localparam int BLK_W  = 128;
    localparam int IV_W   = 96;
    localparam int SIZE_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AAD   = 3'd1,
        ST_PT    = 3'd2,
        ST_EMPTY = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    // First data phase of a freshly accepted job.
    function automatic sched_state_t entry_state(input logic aad_nz, input logic pt_nz);
        if (aad_nz)     return ST_AAD;
        else if (pt_nz) return ST_PT;
        else            return ST_EMPTY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_gcm_sched_outreg.sv
// ============================================================================
// Module   : aes_gcm_sched_outreg
// Purpose  : Valid/ready output holding register for the scheduler beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_gcm_sched_outreg
    import aes_gcm_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    input  logic             i_load,
    input  logic             i_flush,
    input  logic [BLK_W-1:0] i_aad,
    input  logic [BLK_W-1:0] i_pt,
    input  logic             i_new,
    input  logic             i_pt_inst,
    input  logic             i_last,
    output logic             o_valid,
    output logic [BLK_W-1:0] o_aad,
    output logic [BLK_W-1:0] o_plain_text,
    output logic             o_new_instance,
    output logic             o_pt_instance,
    output logic             o_last
);

    logic             r_valid;
    logic [BLK_W-1:0] r_aad;
    logic [BLK_W-1:0] r_pt;
    logic             r_new;
    logic             r_pt_inst;
    logic             r_last;

    // Payload only moves on a load so a stalled beat stays bit-stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_aad     <= '0;
            r_pt      <= '0;
            r_new     <= 1'b0;
            r_pt_inst <= 1'b0;
            r_last    <= 1'b0;
        end else if (i_flush) begin
            r_valid   <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_load;
            if (i_load) begin
                r_aad     <= i_aad;
                r_pt      <= i_pt;
                r_new     <= i_new;
                r_pt_inst <= i_pt_inst;
                r_last    <= i_last;
            end
        end
    end

    assign o_valid        = r_valid;
    assign o_aad          = r_aad;
    assign o_plain_text   = r_pt;
    assign o_new_instance = r_new;
    assign o_pt_instance  = r_pt_inst;
    assign o_last         = r_last;

endmodule

`default_nettype wire

// File: rtl/aes_gcm_instance_scheduler.sv
// ============================================================================
// Module   : aes_gcm_instance_scheduler
// Purpose  : Sequences one AES-GCM instance (AAD then PT blocks) into the
//            GCM pipeline. Optional idle watchdog: AES_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_gcm_instance_scheduler
    import aes_gcm_sched_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_job_valid,
    output logic              o_job_ready,
    input  logic [IV_W-1:0]   i_job_iv,
    input  logic [CNT_W-1:0]  i_job_aad_blks,
    input  logic [CNT_W-1:0]  i_job_pt_blks,
    input  logic [SIZE_W-1:0] i_job_size,
    input  logic              i_blk_valid,
    output logic              o_blk_ready,
    input  logic [BLK_W-1:0]  i_blk_data,
    input  logic              i_pipe_ready,
    output logic              o_valid,
    output logic [IV_W-1:0]   o_iv,
    output logic [BLK_W-1:0]  o_aad,
    output logic [BLK_W-1:0]  o_plain_text,
    output logic [SIZE_W-1:0] o_instance_size,
    output logic              o_new_instance,
    output logic              o_pt_instance,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_abort
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [CNT_W-1:0]  r_aad_rem;
    logic [CNT_W-1:0]  r_pt_rem;
    logic              r_first;
    logic [IV_W-1:0]   r_iv;
    logic [SIZE_W-1:0] r_size;

    logic              w_can_adv;
    logic              w_job_acc;
    logic              w_blk_acc;
    logic              w_load;
    logic              w_aad_dec;
    logic              w_pt_dec;
    logic              w_timeout;
    logic [BLK_W-1:0]  w_beat_aad;
    logic [BLK_W-1:0]  w_beat_pt;
    logic              w_beat_pt_inst;
    logic              w_beat_last;

    assign w_can_adv   = !o_valid || i_pipe_ready;
    assign o_job_ready = (r_state == ST_IDLE);
    assign o_blk_ready = ((r_state == ST_AAD) || (r_state == ST_PT)) && w_can_adv;
    assign w_job_acc   = i_job_valid && o_job_ready;
    assign w_blk_acc   = i_blk_valid && o_blk_ready;
    assign o_busy      = (r_state != ST_IDLE);

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_abort;
    logic              w_data_phase;

    assign w_data_phase = (r_state == ST_AAD) || (r_state == ST_PT);
    assign w_timeout    = w_data_phase && !i_blk_valid &&
                          (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_timeout;
            if (!w_data_phase || w_blk_acc || w_timeout)
                r_wdog <= '0;
            else if (!i_blk_valid)
                r_wdog <= r_wdog + WDOG_W'(1);
        end
    end

    assign o_abort = r_abort;
`else
    assign w_timeout = 1'b0;
    assign o_abort   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_aad_dec      = 1'b0;
        w_pt_dec       = 1'b0;
        w_beat_aad     = '0;
        w_beat_pt      = '0;
        w_beat_pt_inst = 1'b0;
        w_beat_last    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_job_acc)
                    w_state_nxt = entry_state(i_job_aad_blks != '0, i_job_pt_blks != '0);
            end
            ST_AAD: begin
                if (w_blk_acc) begin
                    w_load      = 1'b1;
                    w_aad_dec   = 1'b1;
                    w_beat_aad  = i_blk_data;
                    w_beat_last = (r_aad_rem == CNT_W'(1)) && (r_pt_rem == '0);
                    if (r_aad_rem == CNT_W'(1))
                        w_state_nxt = (r_pt_rem != '0) ? ST_PT : ST_DONE;
                end
            end
            ST_PT: begin
                if (w_blk_acc) begin
                    w_load         = 1'b1;
                    w_pt_dec       = 1'b1;
                    w_beat_pt      = i_blk_data;
                    w_beat_pt_inst = 1'b1;
                    w_beat_last    = (r_pt_rem == CNT_W'(1));
                    if (r_pt_rem == CNT_W'(1))
                        w_state_nxt = ST_DONE;
                end
            end
            ST_EMPTY: begin
                if (w_can_adv) begin
                    w_load      = 1'b1;
                    w_beat_last = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_can_adv)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout)
            w_state_nxt = ST_IDLE;
    end

    // Descriptor latch and remaining-block counters; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aad_rem <= '0;
            r_pt_rem  <= '0;
            r_first   <= 1'b0;
            r_iv      <= '0;
            r_size    <= '0;
        end else if (w_job_acc) begin
            r_aad_rem <= i_job_aad_blks;
            r_pt_rem  <= i_job_pt_blks;
            r_first   <= 1'b1;
            r_iv      <= i_job_iv;
            r_size    <= i_job_size;
        end else if (w_timeout) begin
            r_aad_rem <= '0;
            r_pt_rem  <= '0;
            r_first   <= 1'b0;
        end else begin
            if (w_aad_dec && (r_aad_rem != '0)) r_aad_rem <= r_aad_rem - CNT_W'(1);
            if (w_pt_dec && (r_pt_rem != '0))   r_pt_rem  <= r_pt_rem - CNT_W'(1);
            if (w_load)                         r_first   <= 1'b0;
        end
    end

    assign o_iv            = r_iv;
    assign o_instance_size = r_size;

    aes_gcm_sched_outreg u_outreg (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_adv          (w_can_adv),
        .i_load         (w_load),
        .i_flush        (w_timeout),
        .i_aad          (w_beat_aad),
        .i_pt           (w_beat_pt),
        .i_new          (r_first),
        .i_pt_inst      (w_beat_pt_inst),
        .i_last         (w_beat_last),
        .o_valid        (o_valid),
        .o_aad          (o_aad),
        .o_plain_text   (o_plain_text),
        .o_new_instance (o_new_instance),
        .o_pt_instance  (o_pt_instance),
        .o_last         (o_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_aes_gcm_instance_scheduler.sv
// ============================================================================
// Module   : tb_aes_gcm_instance_scheduler
// Purpose  : Directed self-checking bench for aes_gcm_instance_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_gcm_instance_scheduler;

    logic         clk;
    logic         rst_n;
    logic         job_valid;
    logic         job_ready;
    logic [95:0]  job_iv;
    logic [31:0]  job_aad_blks;
    logic [31:0]  job_pt_blks;
    logic [127:0] job_size;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic         pipe_ready;
    logic         valid;
    logic [95:0]  iv;
    logic [127:0] aad;
    logic [127:0] plain_text;
    logic [127:0] instance_size;
    logic         new_instance;
    logic         pt_instance;
    logic         last;
    logic         busy;
    logic         abort;

    int n_total = 0;
    int n_pass  = 0;

    logic [127:0] d [0:4];

    aes_gcm_instance_scheduler #(
        .CNT_W          (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_job_valid     (job_valid),
        .o_job_ready     (job_ready),
        .i_job_iv        (job_iv),
        .i_job_aad_blks  (job_aad_blks),
        .i_job_pt_blks   (job_pt_blks),
        .i_job_size      (job_size),
        .i_blk_valid     (blk_valid),
        .o_blk_ready     (blk_ready),
        .i_blk_data      (blk_data),
        .i_pipe_ready    (pipe_ready),
        .o_valid         (valid),
        .o_iv            (iv),
        .o_aad           (aad),
        .o_plain_text    (plain_text),
        .o_instance_size (instance_size),
        .o_new_instance  (new_instance),
        .o_pt_instance   (pt_instance),
        .o_last          (last),
        .o_busy          (busy),
        .o_abort         (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [95:0] v, input int na, input int np, input logic [127:0] sz);
        job_valid    = 1'b1;
        job_iv       = v;
        job_aad_blks = 32'(na);
        job_pt_blks  = 32'(np);
        job_size     = sz;
        cyc();
        job_valid    = 1'b0;
    endtask

    initial begin
        d[0] = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
        d[1] = 128'h1011_1213_1415_1617_1819_1a1b_1c1d_1e1f;
        d[2] = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
        d[3] = 128'hffff_0000_ffff_0000_5555_aaaa_5555_aaaa;
        d[4] = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        rst_n = 1'b0; job_valid = 1'b0; job_iv = '0; job_aad_blks = '0;
        job_pt_blks = '0; job_size = '0; blk_valid = 1'b0; blk_data = '0;
        pipe_ready = 1'b1;
        cyc(); cyc();
        chk("rst_job_ready", job_ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_iv", iv, 0);
        chk("rst_size", instance_size, 0);
        chk("rst_blk_ready", blk_ready, 0);
        chk("rst_abort", abort, 0);
        rst_n = 1'b1;
        cyc();

        // Job 1: aad=2, pt=3, full throughput.
        start_job(96'h1234_5678_9abc_def0_1122_3344, 2, 3, {64'd256, 64'd384});
        chk("j1_busy", busy, 1);
        chk("j1_job_ready", job_ready, 0);
        chk("j1_blk_ready", blk_ready, 1);
        chk("j1_valid_pre", valid, 0);
        blk_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            blk_data = d[i];
            cyc();
            chk($sformatf("j1_valid_%0d", i), valid, 1);
            chk($sformatf("j1_aad_%0d", i), aad, (i < 2) ? d[i] : 128'd0);
            chk($sformatf("j1_pt_%0d", i), plain_text, (i < 2) ? 128'd0 : d[i]);
            chk($sformatf("j1_ptinst_%0d", i), pt_instance, (i < 2) ? 1'b0 : 1'b1);
            chk($sformatf("j1_new_%0d", i), new_instance, (i == 0) ? 1'b1 : 1'b0);
            chk($sformatf("j1_last_%0d", i), last, (i == 4) ? 1'b1 : 1'b0);
            chk($sformatf("j1_iv_%0d", i), iv, 96'h1234_5678_9abc_def0_1122_3344);
        end
        blk_valid = 1'b0;
        chk("j1_size", instance_size, {64'd256, 64'd384});
        chk("j1_done_job_ready", job_ready, 0);
        chk("j1_done_blk_ready", blk_ready, 0);
        cyc();
        chk("j1_idle_job_ready", job_ready, 1);
        chk("j1_idle_valid", valid, 0);
        chk("j1_idle_busy", busy, 0);

        // Job 2: aad=0, pt=1.
        start_job(96'haaaa_bbbb_cccc_dddd_eeee_ffff, 0, 1, {64'd0, 64'd128});
        blk_valid = 1'b1;
        blk_data  = d[2];
        cyc();
        blk_valid = 1'b0;
        chk("j2_valid", valid, 1);
        chk("j2_pt", plain_text, d[2]);
        chk("j2_aad", aad, 0);
        chk("j2_new", new_instance, 1);
        chk("j2_last", last, 1);
        chk("j2_ptinst", pt_instance, 1);
        cyc();
        chk("j2_idle", job_ready, 1);

        // Job 3: aad=0, pt=0 -> one zero beat.
        start_job(96'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f, 0, 0, 128'd0);
        chk("j3_valid_pre", valid, 0);
        chk("j3_blk_ready", blk_ready, 0);
        cyc();
        chk("j3_valid", valid, 1);
        chk("j3_aad", aad, 0);
        chk("j3_pt", plain_text, 0);
        chk("j3_new", new_instance, 1);
        chk("j3_last", last, 1);
        chk("j3_ptinst", pt_instance, 0);
        cyc();
        chk("j3_idle", job_ready, 1);
        chk("j3_idle_valid", valid, 0);

        // Job 4: aad=1, pt=2 with a 3-cycle stall on beat 2.
        start_job(96'h4444_5555_6666_7777_8888_9999, 1, 2, {64'd128, 64'd256});
        blk_valid = 1'b1;
        blk_data  = d[0];
        cyc();
        chk("j4_b1_aad", aad, d[0]);
        chk("j4_b1_new", new_instance, 1);
        blk_data = d[1];
        cyc();
        chk("j4_b2_pt", plain_text, d[1]);
        chk("j4_b2_new", new_instance, 0);
        pipe_ready = 1'b0;
        blk_data   = d[3];
        #1;
        chk("j4_stall_blk_ready", blk_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("j4_hold_valid_%0d", i), valid, 1);
            chk($sformatf("j4_hold_pt_%0d", i), plain_text, d[1]);
            chk($sformatf("j4_hold_last_%0d", i), last, 0);
            chk($sformatf("j4_hold_blk_ready_%0d", i), blk_ready, 0);
            chk($sformatf("j4_hold_abort_%0d", i), abort, 0);
        end
        pipe_ready = 1'b1;
        cyc();
        blk_valid = 1'b0;
        chk("j4_b3_pt", plain_text, d[3]);
        chk("j4_b3_last", last, 1);
        chk("j4_b3_ptinst", pt_instance, 1);
        cyc();
        chk("j4_idle_valid", valid, 0);
        chk("j4_idle", job_ready, 1);

        // Job 5: reset after beat 1 of a 4-block job.
        start_job(96'h1357_9bdf_2468_ace0_1111_2222, 2, 2, {64'd256, 64'd256});
        blk_valid = 1'b1;
        blk_data  = d[4];
        cyc();
        chk("j5_b1_valid", valid, 1);
        rst_n = 1'b0;
        blk_valid = 1'b0;
        #1;
        chk("j5_rst_valid", valid, 0);
        chk("j5_rst_busy", busy, 0);
        chk("j5_rst_job_ready", job_ready, 1);
        cyc();
        rst_n = 1'b1;
        cyc();
        start_job(96'h0000_0000_0000_0000_0000_0077, 1, 0, {64'd128, 64'd0});
        blk_valid = 1'b1;
        blk_data  = d[3];
        cyc();
        blk_valid = 1'b0;
        chk("j6_new", new_instance, 1);
        chk("j6_last", last, 1);
        chk("j6_aad", aad, d[3]);
        chk("j6_ptinst", pt_instance, 0);
        chk("j6_iv", iv, 96'h77);
        cyc();
        chk("j6_idle", job_ready, 1);

`ifdef AES_SCHED_TIMEOUT_EN
        // Watchdog: aad=2, feed one block, then starve input.
        start_job(96'h9999_8888_7777_6666_5555_4444, 2, 0, {64'd256, 64'd0});
        blk_valid = 1'b1;
        blk_data  = d[1];
        cyc();
        blk_valid = 1'b0;
        chk("to_b1_valid", valid, 1);
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk($sformatf("to_wait_abort_%0d", i), abort, 0);
            chk($sformatf("to_wait_busy_%0d", i), busy, 1);
        end
        cyc();
        chk("to_abort", abort, 1);
        chk("to_busy", busy, 0);
        chk("to_job_ready", job_ready, 1);
        chk("to_valid", valid, 0);
        cyc();
        chk("to_abort_pulse", abort, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
